// File: rtl/trial_session_ctrl_pkg.sv
// Shared definitions for the trial session controller: phase codes,
// score ceiling and the timer width helper.
package trial_session_ctrl_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_WAIT_ANS = 2'd1,
    PH_FEEDBACK = 2'd2,
    PH_DONE     = 2'd3
  } phase_e;

  localparam logic [3:0] SCORE_MAX = 4'd9;

  localparam int TIMEOUT_CYC_DEF = 250000000;
  localparam int FB_CYC_DEF      = 50000000;

  // The shared timer only ever counts up to (window - 1), so the longest
  // window alone decides how many bits it needs.
  function automatic int timer_width(input int timeout_cyc, input int fb_cyc);
    int longest;
    longest = (timeout_cyc > fb_cyc) ? timeout_cyc : fb_cyc;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/trial_session_ctrl_round_timer.sv
// Clearable free-running cycle counter with a terminal-count flag. One
// instance serves both the answer window and the feedback hold.
module round_timer
  import trial_session_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         clr,
  input  logic [W-1:0] term_val,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Restart from zero on clear, otherwise advance by one each cycle.
  always_comb begin
    cnt_d = clr ? '0 : cnt_q + W'(1);
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign term = (cnt_q == term_val);

endmodule

// File: rtl/trial_session_ctrl.sv
// Session controller for the letter-guessing trainer: sequences rounds,
// judges submissions, enforces the answer window and feedback hold.
module trial_session_ctrl
  import trial_session_ctrl_pkg::*;
#(
  parameter int ROUNDS      = 9,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FB_CYC      = FB_CYC_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Check,
  input  logic       Correct,
  output logic       Req_Letter,
  output logic [3:0] Score,
  output logic [3:0] Round,
  output logic [1:0] Tries_Left,
  output logic       Result_Ok,
  output logic       Result_Bad,
  output logic       Timed_Out,
  output logic       Done,
  output logic [1:0] Phase
);

  localparam int                TMR_W    = timer_width(TIMEOUT_CYC, FB_CYC);
  localparam logic [TMR_W-1:0]  TO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  FB_LAST  = TMR_W'(FB_CYC - 1);
  localparam logic [3:0]        ROUNDS_L = 4'(ROUNDS);
  localparam logic [1:0]        TRIES_L  = 2'(MAX_TRIES);

  phase_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] score_q, score_d;
  logic [1:0] tries_q, tries_d;
  logic       ok_q, ok_d;
  logic       bad_q, bad_d;
  logic       to_q, to_d;
  logic       req_q, req_d;

  logic             tmr_clr;
  logic             tmr_term;
  logic [TMR_W-1:0] tmr_last;

  assign tmr_last = (state_q == PH_FEEDBACK) ? FB_LAST : TO_LAST;

  round_timer #(.W(TMR_W)) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .clr      (tmr_clr),
    .term_val (tmr_last),
    .term     (tmr_term)
  );

  // Next-state and next-output logic; the timer is cleared on every state
  // entry and on a wrong answer that keeps the round alive.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    score_d = score_q;
    tries_d = tries_q;
    ok_d    = ok_q;
    bad_d   = bad_q;
    to_d    = to_q;
    req_d   = 1'b0;
    tmr_clr = 1'b0;
    case (state_q)
      PH_IDLE, PH_DONE: begin
        tmr_clr = 1'b1;
        if (Start) begin
          state_d = PH_WAIT_ANS;
          round_d = 4'd1;
          score_d = 4'd0;
          tries_d = TRIES_L;
          req_d   = 1'b1;
        end
      end
      PH_WAIT_ANS: begin
        // A submission on the last window cycle beats the timeout.
        if (Check) begin
          tmr_clr = 1'b1;
          if (Correct) begin
            score_d = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 4'd1;
            ok_d    = 1'b1;
            state_d = PH_FEEDBACK;
          end else begin
            tries_d = tries_q - 2'd1;
            if (tries_q == 2'd1) begin
              bad_d   = 1'b1;
              state_d = PH_FEEDBACK;
            end
          end
        end else if (tmr_term) begin
          tmr_clr = 1'b1;
          tries_d = 2'd0;
          bad_d   = 1'b1;
          to_d    = 1'b1;
          state_d = PH_FEEDBACK;
        end
      end
      PH_FEEDBACK: begin
        if (tmr_term) begin
          tmr_clr = 1'b1;
          ok_d    = 1'b0;
          bad_d   = 1'b0;
          to_d    = 1'b0;
          if (round_q < ROUNDS_L) begin
            round_d = round_q + 4'd1;
            tries_d = TRIES_L;
            req_d   = 1'b1;
            state_d = PH_WAIT_ANS;
          end else begin
            state_d = PH_DONE;
          end
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  // State and output registers; reset drops everything back to idle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= PH_IDLE;
      round_q <= 4'd0;
      score_q <= 4'd0;
      tries_q <= 2'd0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      to_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      score_q <= score_d;
      tries_q <= tries_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      to_q    <= to_d;
      req_q   <= req_d;
    end
  end

  assign Req_Letter = req_q;
  assign Score      = score_q;
  assign Round      = round_q;
  assign Tries_Left = tries_q;
  assign Result_Ok  = ok_q;
  assign Result_Bad = bad_q;
  assign Timed_Out  = to_q;
  assign Done       = (state_q == PH_DONE);
  assign Phase      = state_q;

endmodule
